// File: rtl/lane_scroller.sv
// One obstacle lane held as a circular bitmap; rotates one column every
// (i_Speed+1) ticks while running, and flags a frog/obstacle overlap.
module lane_scroller #(
  parameter int WIDTH   = 16,
  parameter int COL_W   = 4,
  parameter int SPEED_W = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Tick,
  input  logic               i_Enable,
  input  logic               i_Dir,
  input  logic [SPEED_W-1:0] i_Speed,
  input  logic               i_Load,
  input  logic [WIDTH-1:0]   i_Pattern,
  input  logic [COL_W-1:0]   i_Frog_Col,
  input  logic               i_Frog_In_Lane,
  output logic [WIDTH-1:0]   o_Lane,
  output logic               o_Step,
  output logic               o_Hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [COL_W:0] WIDTH_C = (COL_W+1)'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lane_q, lane_d, lane_rot;
  logic [SPEED_W-1:0] cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               hit_q, hit_d;
  logic               col_ok;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    lane_rot = i_Dir ? {lane_q[0], lane_q[WIDTH-1:1]}
                     : {lane_q[WIDTH-2:0], lane_q[WIDTH-1]};
    // Column range guard keeps narrow lanes safe when COL_W over-covers WIDTH.
    col_ok   = {1'b0, i_Frog_Col} < WIDTH_C;
    hit_d    = i_Frog_In_Lane & col_ok & lane_q[i_Frog_Col];

    if (i_Load) begin
      lane_d  = i_Pattern;
      cnt_d   = '0;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (!i_Enable) begin
            state_d = S_PAUSE;
          end else if (i_Tick) begin
            // >= so a speed lowered below the running count steps at once.
            if (cnt_q >= i_Speed) begin
              lane_d = lane_rot;
              cnt_d  = '0;
              step_d = 1'b1;
            end else begin
              cnt_d  = cnt_q + SPEED_W'(1);
            end
          end
        end
        S_PAUSE: if (i_Enable) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_Lane = lane_q;
  assign o_Step = step_q;
  assign o_Hit  = hit_q;

endmodule

// File: tb/tb_lane_scroller.sv
// Self-checking bench for lane_scroller: directed scenarios plus a randomized
// run against a cycle-level behavioural model.
module tb_lane_scroller;

  logic        clk = 1'b0;
  logic        rst, tick, en, dir, load, fin;
  logic [3:0]  speed, fcol;
  logic [15:0] pat;
  logic [15:0] o_lane;
  logic        o_step, o_hit;

  int total = 0;
  int bad   = 0;

  // behavioural model: mode 0=idle 1=running 2=paused
  int          m_mode;
  int          m_cnt;
  logic [15:0] m_lane;
  logic        m_step, m_hit;

  always #5 clk = ~clk;

  lane_scroller #(.WIDTH(16), .COL_W(4), .SPEED_W(4)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick), .i_Enable(en), .i_Dir(dir),
    .i_Speed(speed), .i_Load(load), .i_Pattern(pat), .i_Frog_Col(fcol),
    .i_Frog_In_Lane(fin), .o_Lane(o_lane), .o_Step(o_step), .o_Hit(o_hit)
  );

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_lane = '0; m_step = 0; m_hit = 0;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge,
  // then settle 1 time unit past the edge before returning.
  task automatic cyc();
    int          mode_n = m_mode;
    int          cnt_n  = m_cnt;
    logic [15:0] lane_n = m_lane;
    logic        step_n = 0;
    logic        hit_n;
    hit_n = fin && (int'(fcol) < 16) && ((m_lane >> fcol) & 16'h1) != 0;
    if (load) begin
      lane_n = pat; cnt_n = 0; mode_n = 1;
    end else if (m_mode == 1) begin
      if (!en) mode_n = 2;
      else if (tick) begin
        if (m_cnt >= int'(speed)) begin
          lane_n = dir ? ((m_lane >> 1) | (m_lane << 15)) : ((m_lane << 1) | (m_lane >> 15));
          cnt_n = 0; step_n = 1;
        end else cnt_n = m_cnt + 1;
      end
    end else if (m_mode == 2 && en) mode_n = 1;
    @(posedge clk);
    m_mode = mode_n; m_cnt = cnt_n; m_lane = lane_n; m_step = step_n; m_hit = hit_n;
    #1;
  endtask

  task automatic idle_inputs();
    tick = 0; en = 1; dir = 0; load = 0; pat = '0; speed = 0; fcol = 0; fin = 0;
  endtask

  task automatic hard_reset();
    rst = 1; #3; @(posedge clk); #1; rst = 0; model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    hard_reset();
    total++;
    if (o_lane !== 16'h0 || o_step !== 1'b0 || o_hit !== 1'b0) begin
      bad++; $display("FAIL reset lane=%h step=%b hit=%b want 0000/0/0", o_lane, o_step, o_hit);
    end
  endtask

  task automatic test_basic_shift();
    logic [15:0] exp_l;
    idle_inputs(); hard_reset();
    load = 1; pat = 16'h0001; cyc(); load = 0;
    exp_l = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      tick = 1; cyc(); tick = 0;
      exp_l = exp_l << 1;
      total++;
      if (o_lane !== exp_l || o_step !== 1'b1) begin
        bad++; $display("FAIL basic_shift%0d lane=%h step=%b want %h/1", i, o_lane, o_step, exp_l);
      end
      cyc();
      total++;
      if (o_step !== 1'b0 || o_lane !== exp_l) begin
        bad++; $display("FAIL basic_gap%0d lane=%h step=%b want %h/0", i, o_lane, o_step, exp_l);
      end
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    load = 1; pat = 16'h8001; cyc(); load = 0;
    tick = 1; cyc(); tick = 0;
    total++;
    if (o_lane !== 16'h0003) begin
      bad++; $display("FAIL wrap_msb lane=%h want 0003", o_lane);
    end
    load = 1; pat = 16'h0001; cyc(); load = 0;
    dir = 1; tick = 1; cyc(); tick = 0;
    total++;
    if (o_lane !== 16'h8000 || o_step !== 1'b1) begin
      bad++; $display("FAIL wrap_lsb lane=%h step=%b want 8000/1", o_lane, o_step);
    end
    dir = 0;
  endtask

  task automatic test_speed_pause();
    int steps = 0;
    int at[$];
    idle_inputs(); speed = 3;
    load = 1; pat = 16'h0001; cyc(); load = 0;
    for (int i = 1; i <= 8; i++) begin
      tick = 1; cyc(); tick = 0;
      if (o_step) begin steps++; at.push_back(i); end
      cyc();
    end
    total++;
    if (steps != 2 || at.size() != 2 || at[0] != 4 || at[1] != 8 || o_lane !== 16'h0004) begin
      bad++; $display("FAIL speed3 steps=%0d lane=%h want 2 steps on ticks 4,8 lane 0004", steps, o_lane);
    end
    // two ticks counted, then a 5-tick pause, then the count resumes
    for (int i = 0; i < 2; i++) begin tick = 1; cyc(); tick = 0; end
    en = 0; cyc();
    steps = 0;
    for (int i = 0; i < 5; i++) begin tick = 1; cyc(); if (o_step) steps++; end
    tick = 0; en = 1; cyc();
    total++;
    if (steps != 0 || o_lane !== 16'h0004) begin
      bad++; $display("FAIL pause steps=%0d lane=%h want 0/0004", steps, o_lane);
    end
    tick = 1; cyc();
    total++;
    if (o_step !== 1'b0) begin
      bad++; $display("FAIL resume_t1 step=%b want 0", o_step);
    end
    cyc(); tick = 0;
    total++;
    if (o_step !== 1'b1 || o_lane !== 16'h0008) begin
      bad++; $display("FAIL resume_t2 step=%b lane=%h want 1/0008", o_step, o_lane);
    end
  endtask

  task automatic test_load_priority();
    idle_inputs(); hard_reset();
    tick = 1;
    for (int i = 0; i < 3; i++) cyc();
    total++;
    if (o_lane !== 16'h0 || o_step !== 1'b0) begin
      bad++; $display("FAIL idle_ticks lane=%h step=%b want 0000/0", o_lane, o_step);
    end
    load = 1; pat = 16'h1234; cyc(); load = 0; tick = 0;
    total++;
    if (o_lane !== 16'h1234 || o_step !== 1'b0) begin
      bad++; $display("FAIL load_tick lane=%h step=%b want 1234/0", o_lane, o_step);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    load = 1; pat = 16'h0010; cyc(); load = 0;
    fcol = 4; fin = 1; cyc();
    total++;
    if (o_hit !== 1'b1) begin bad++; $display("FAIL hit_col4 hit=%b want 1", o_hit); end
    fin = 0; cyc();
    total++;
    if (o_hit !== 1'b0) begin bad++; $display("FAIL hit_notlane hit=%b want 0", o_hit); end
    fin = 1; fcol = 5; cyc();
    total++;
    if (o_hit !== 1'b0) begin bad++; $display("FAIL hit_col5 hit=%b want 0", o_hit); end
    fin = 0;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    load = 1; pat = 16'hF0F1; cyc(); load = 0;
    fcol = 0; fin = 1; tick = 1; cyc(); cyc();
    #2 rst = 1; #1;
    model_reset();
    total++;
    if (o_lane !== 16'h0 || o_step !== 1'b0 || o_hit !== 1'b0) begin
      bad++; $display("FAIL async_rst lane=%h step=%b hit=%b want 0000/0/0", o_lane, o_step, o_hit);
    end
    @(posedge clk); #1; rst = 0;
    for (int i = 0; i < 4; i++) cyc();
    tick = 0; fin = 0;
    total++;
    if (o_lane !== 16'h0 || o_step !== 1'b0) begin
      bad++; $display("FAIL post_rst_ticks lane=%h step=%b want 0000/0", o_lane, o_step);
    end
  endtask

  task automatic test_random();
    idle_inputs(); hard_reset();
    for (int i = 0; i < 400; i++) begin
      tick = ($urandom_range(0, 1) == 1);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 29) == 0) || (i == 2);
      pat  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) speed = 4'($urandom_range(0, 4));
      fcol = 4'($urandom);
      fin  = ($urandom_range(0, 1) == 1);
      cyc();
      total++;
      if (o_lane !== m_lane || o_step !== m_step || o_hit !== m_hit) begin
        bad++;
        $display("FAIL rnd%0d lane=%h step=%b hit=%b want %h/%b/%b",
                 i, o_lane, o_step, o_hit, m_lane, m_step, m_hit);
      end
    end
  endtask

  initial begin
    rst = 1; idle_inputs(); model_reset();
    test_reset();
    test_basic_shift();
    test_wrap();
    test_speed_pause();
    test_load_priority();
    test_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
